alu_share_ctrl: RTL and testbench

- Sequences the shared 32-bit ALU (ALU_32bit) and arbitrates it between two requesters, e.g. the main execute path and a branch/address helper.
- Each requester issues {op, A, B} with a valid/ready handshake.
- The controller registers operands, runs the ALU for one cycle (or MUL_LATENCY cycles for multiply), registers the result and zero flag, and returns them on a shared response bus with per-requester valid/ready.

---
 rtl/alu_pkg.sv | 13 +
 rtl/ALU_32bit.sv | 18 +
 rtl/alu_share_ctrl.sv | 71 +++++++
 tb/tb_alu_share_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, controller states and op legality helper.
package alu_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  function automatic logic is_illegal_op(input logic [2:0] op);
    return op == 3'b011 || op == 3'b111;
  endfunction
endpackage

// File: rtl/ALU_32bit.sv
// ALU_32bit: combinational ALU; SLT and illegal codes yield zero here.
module ALU_32bit
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);
  always_comb
    y = op == OP_AND ? a & b :
        op == OP_OR  ? a | b :
        op == OP_ADD ? a + b :
        op == OP_SUB ? a - b :
        op == OP_MUL ? a * b : '0;
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin arbitration of one shared ALU between two requesters.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MUL_LATENCY = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [5:0]            req_op,
  input  logic [2*DATA_W-1:0]   req_a,
  input  logic [2*DATA_W-1:0]   req_b,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [DATA_W-1:0]     resp_result,
  output logic                  resp_zero,
  output logic                  resp_illegal,
  output logic                  busy
);
  localparam logic [3:0] MUL_CNT = 4'(MUL_LATENCY - 1);
  state_t state, state_nx;
  logic g, last_grant, owner, accept, resp_hs, done;
  logic [2:0] op_q, sel_op;
  logic [DATA_W-1:0] a_q, b_q, alu_y, exec_y;
  logic [3:0] exec_cnt;
  ALU_32bit #(.DATA_W(DATA_W)) u_alu (.op(op_q), .a(a_q), .b(b_q), .y(alu_y));
  always_comb begin
    g = &req_valid ? ~last_grant : req_valid[1];
    sel_op = g ? req_op[5:3] : req_op[2:0];
    accept = state == IDLE && req_valid[g];
    req_ready = accept ? (g ? 2'b10 : 2'b01) : 2'b00;
    resp_valid = state == RESP ? (owner ? 2'b10 : 2'b01) : 2'b00;
    resp_hs = |(resp_valid & resp_ready);
    done = state == EXEC && exec_cnt == 4'd0;
    // SLT is resolved here so the result never depends on stale ALU output
    exec_y = op_q == OP_SLT ? {{(DATA_W-1){1'b0}}, a_q < b_q} : alu_y;
    state_nx = accept ? EXEC : done ? RESP : resp_hs ? IDLE : state;
    busy = state != IDLE;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= IDLE;
      last_grant <= 1'b1;
      owner <= 1'b0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      exec_cnt <= '0;
      resp_result <= '0;
      resp_zero <= 1'b0;
      resp_illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q <= sel_op;
        a_q <= g ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
        b_q <= g ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
        owner <= g;
        last_grant <= g;
        exec_cnt <= sel_op == OP_MUL ? MUL_CNT : 4'd0;
      end else if (state == EXEC && exec_cnt != 4'd0)
        exec_cnt <= exec_cnt - 4'd1;
      if (done) begin
        resp_result <= exec_y;
        resp_zero <= exec_y == '0;
        resp_illegal <= is_illegal_op(op_q);
      end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed stimulus checked every cycle against a transaction-level model.
module tb_alu_share_ctrl;
  localparam int MUL_LATENCY = 3;
  logic CLK = 0, RST = 0;
  logic [1:0] req_valid = 0, req_ready, resp_valid, resp_ready = 2'b11;
  logic [5:0] req_op = 0;
  logic [63:0] req_a = 0, req_b = 0;
  logic [31:0] resp_result;
  logic resp_zero, resp_illegal, busy;
  int n_chk = 0, n_fail = 0;
  logic in_flight = 0, last_exp = 1, m_own = 0, eg;
  int cnt = 0, lat = 2, gn = 0;
  int glog [64];
  logic [2:0] m_op;
  logic [31:0] m_res, m_a, m_b, last_res;
  logic [1:0] err, erv;
  logic last_zero, last_ill, last_own;

  alu_share_ctrl #(.DATA_W(32), .MUL_LATENCY(MUL_LATENCY)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_illegal(resp_illegal), .busy(busy));

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000: return a & b;
      3'b001: return a | b;
      3'b010: return a + b;
      3'b100: return a - b;
      3'b101: return a * b;
      3'b110: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge CLK) begin
    if (!RST) begin
      in_flight = 0;
      last_exp = 1;
      cnt = 0;
      chk("reset_outs", {25'd0, busy, req_ready, resp_valid, resp_zero, resp_illegal, resp_result}, 64'd0);
    end else begin
      if (in_flight) cnt++;
      eg = (req_valid == 2'b11) ? ~last_exp : req_valid[1];
      err = (!in_flight && req_valid[eg]) ? (eg ? 2'b10 : 2'b01) : 2'b00;
      erv = (in_flight && cnt >= lat) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", req_ready, err);
      chk("busy", busy, in_flight);
      chk("resp_valid", resp_valid, erv);
      if (erv != 0) begin
        chk("resp_result", resp_result, m_res);
        chk("resp_zero", resp_zero, m_res == 0);
        chk("resp_illegal", resp_illegal, m_op == 3'b011 || m_op == 3'b111);
      end
      if (err != 0) begin
        in_flight = 1;
        cnt = 0;
        m_own = eg;
        last_exp = eg;
        m_op = eg ? req_op[5:3] : req_op[2:0];
        m_a = eg ? req_a[63:32] : req_a[31:0];
        m_b = eg ? req_b[63:32] : req_b[31:0];
        m_res = model(m_op, m_a, m_b);
        lat = (m_op == 3'b101) ? MUL_LATENCY + 1 : 2;
        glog[gn] = int'(eg);
        gn++;
      end else if (|(erv & resp_ready)) begin
        in_flight = 0;
        last_res = resp_result;
        last_zero = resp_zero;
        last_ill = resp_illegal;
        last_own = resp_valid[1];
      end
    end
  end

  task automatic issue(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit ok = 0;
    if (i == 0) begin
      req_op[2:0] = op; req_a[31:0] = a; req_b[31:0] = b;
    end else begin
      req_op[5:3] = op; req_a[63:32] = a; req_b[63:32] = b;
    end
    req_valid[i] = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge CLK);
      if (req_ready[i]) ok = 1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge CLK); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge CLK);
      if (!in_flight) ok = 1;
    end
    if (!ok) chk("resp_timeout", 0, 1);
    @(posedge CLK); #1;
  endtask

  task automatic rx(input string nm, input logic [31:0] res, input logic z, input logic il, input logic own);
    chk({nm, "_res"}, last_res, res);
    chk({nm, "_zero"}, last_zero, z);
    chk({nm, "_ill"}, last_ill, il);
    chk({nm, "_owner"}, last_own, own);
  endtask

  initial begin
    int base, n;
    #1 chk("por_outs", {busy, req_ready, resp_valid, resp_zero, resp_illegal}, 0);
    repeat (3) @(posedge CLK);
    #1 RST = 1;
    issue(0, 3'b101, 32'd7, 32'd9);
    @(posedge CLK); #1;
    RST = 0;
    #1 chk("async_reset", {busy, req_ready, resp_valid, resp_zero, resp_illegal, resp_result}, 0);
    @(posedge CLK); #1 RST = 1;
    repeat (10) @(posedge CLK);
    #1;
    base = gn;
    n = 0;
    req_op = {3'b010, 3'b010};
    req_a = {32'd2, 32'd1};
    req_b = {32'd2, 32'd1};
    req_valid = 2'b11;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge CLK);
      if (req_ready != 0) n++;
    end
    @(posedge CLK); #1 req_valid = 0;
    wait_idle();
    chk("rr_count", n, 4);
    for (int k = 0; k < 4; k++) chk("rr_order", glog[base + k], k % 2);
    issue(0, 3'b010, 32'd5, 32'd7);
    wait_idle();
    rx("add", 32'd12, 0, 0, 0);
    issue(0, 3'b100, 32'd9, 32'd9);
    wait_idle();
    rx("sub", 32'd0, 1, 0, 0);
    issue(1, 3'b101, 32'h0001_0000, 32'h0001_0000);
    wait_idle();
    rx("mul_wrap", 32'd0, 1, 0, 1);
    issue(1, 3'b101, 32'hFFFF_FFFF, 32'd2);
    wait_idle();
    rx("mul_low", 32'hFFFF_FFFE, 0, 0, 1);
    issue(0, 3'b110, 32'd3, 32'd4);
    wait_idle();
    rx("slt_lt", 32'd1, 0, 0, 0);
    issue(0, 3'b110, 32'd4, 32'd3);
    wait_idle();
    rx("slt_ge", 32'd0, 1, 0, 0);
    issue(1, 3'b111, 32'd5, 32'd6);
    wait_idle();
    rx("illegal", 32'd0, 1, 1, 1);
    resp_ready = 2'b00;
    issue(1, 3'b010, 32'd10, 32'd20);
    repeat (6) @(posedge CLK);
    #1 resp_ready = 2'b01;
    @(posedge CLK); #1;
    resp_ready = 2'b00;
    @(negedge CLK);
    chk("bp_held", resp_valid, 2'b10);
    @(posedge CLK); #1 resp_ready = 2'b10;
    wait_idle();
    rx("bp", 32'd30, 0, 0, 1);
    resp_ready = 2'b11;
    repeat (3) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
